// File: rtl/fix2fp.sv
// Pipelined signed fixed-point to IEEE-754 float converter: 3 stages, valid/ready on both sides.
// Optional macro FIX2FP_INEXACT_EN adds out_inexact and a saturating inexact_cnt.
module fix2fp #(
  parameter int I_EXP     = 8,
  parameter int I_MNT     = 23,
  parameter int I_DATA    = I_EXP + I_MNT + 1,
  parameter int FRAC_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [I_DATA-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [I_DATA-1:0] out_data,
  output logic              out_valid,
`ifdef FIX2FP_INEXACT_EN
  output logic              out_inexact,
  output logic [15:0]       inexact_cnt,
`endif
  input  logic              out_ready
);

  localparam int PW    = $clog2(I_DATA);
  localparam int BIAS  = (1 << (I_EXP - 1)) - 1;
  localparam int E_MAX = I_DATA - 1 - FRAC_BITS + BIAS;
  localparam int E_MIN = BIAS - FRAC_BITS;

  if (E_MIN < 1 || E_MAX > (1 << I_EXP) - 2) begin : g_range_check
    $error("fix2fp: fixed-point range does not fit the normal exponent range");
  end

  // Stage 1: sign, magnitude, zero flag
  logic              v1;
  logic              sign1;
  logic              zero1;
  logic [I_DATA-1:0] mag1;

  // Stage 2: normalised magnitude with the hidden one dropped, biased exponent
  logic              v2;
  logic              sign2;
  logic              zero2;
  logic [I_EXP-1:0]  exp2;
  logic [I_DATA-2:0] norm2;

  // Stage 3: packed float
  logic              v3;
  logic [I_DATA-1:0] res3;
  logic              inexact3;

  logic adv0, adv1, adv2, adv3;

  assign adv3     = v3 & out_ready;
  assign adv2     = v2 & (~v3 | adv3);
  assign adv1     = v1 & (~v2 | adv2);
  assign in_ready = ~v1 | adv1;
  assign adv0     = in_valid & in_ready;

  logic [PW-1:0] lead;
  logic [PW-1:0] shamt;

  always_comb begin
    lead = '0;
    for (int i = 0; i < I_DATA; i++) begin
      if (mag1[i]) lead = PW'(i);
    end
    shamt = PW'(I_DATA - 1) - lead;
  end

  logic [I_MNT-1:0]    mant;
  logic                guard;
  logic                sticky;
  logic                rnd_inc;
  logic [I_DATA-2:0]   rounded;
  logic [I_DATA-1:0]   packed_res;

  always_comb begin
    mant    = norm2[I_DATA-2 -: I_MNT];
    guard   = norm2[I_DATA-2-I_MNT];
    sticky  = |norm2[I_DATA-3-I_MNT:0];
    rnd_inc = guard & (sticky | mant[0]);
    // A mantissa carry-out ripples into the exponent field naturally
    rounded = {exp2, mant} + {{(I_DATA-2){1'b0}}, rnd_inc};
    packed_res = zero2 ? '0 : {sign2, rounded};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      zero1 <= 1'b0;
      mag1  <= '0;
    end else begin
      v1 <= adv0 | (v1 & ~adv1);
      if (adv0) begin
        sign1 <= in_data[I_DATA-1];
        zero1 <= (in_data == '0);
        mag1  <= in_data[I_DATA-1] ? (~in_data + I_DATA'(1)) : in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2    <= 1'b0;
      sign2 <= 1'b0;
      zero2 <= 1'b0;
      exp2  <= '0;
      norm2 <= '0;
    end else begin
      v2 <= adv1 | (v2 & ~adv2);
      if (adv1) begin
        sign2 <= sign1;
        zero2 <= zero1;
        exp2  <= I_EXP'(int'(lead) + BIAS - FRAC_BITS);
        norm2 <= (I_DATA-1)'(mag1 << shamt);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v3       <= 1'b0;
      res3     <= '0;
      inexact3 <= 1'b0;
    end else begin
      v3 <= adv2 | (v3 & ~adv3);
      if (adv2) begin
        res3     <= packed_res;
        inexact3 <= guard | sticky;
      end
    end
  end

  assign out_valid = v3;
  assign out_data  = res3;

`ifdef FIX2FP_INEXACT_EN
  assign out_inexact = inexact3 & v3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inexact_cnt <= '0;
    end else if (adv3 && inexact3 && inexact_cnt != 16'hFFFF) begin
      inexact_cnt <= inexact_cnt + 16'd1;
    end
  end
`else
  logic unused_inexact;
  assign unused_inexact = inexact3;
`endif

endmodule

// File: tb/tb_fix2fp.sv
// Directed bench for fix2fp: real-arithmetic reference model, scoreboard monitor, literal pins.
module tb_fix2fp;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef FIX2FP_INEXACT_EN
  logic        out_inexact;
  logic [15:0] inexact_cnt;
`endif

  fix2fp dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
`ifdef FIX2FP_INEXACT_EN
    .out_inexact(out_inexact),
    .inexact_cnt(inexact_cnt),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        inex;
    int          acc;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_inex_cnt = 0;
  bit   chk_lat = 1'b0;
  bit   hold_prev = 1'b0;
  logic [31:0] prev_data;

  always @(posedge clk) cyc++;

  // Value/1 format: scale by 2^-8 in double precision (exact), then round the
  // double's 52-bit fraction to 23 bits with ties-to-even. Bit 32 = inexact.
  function automatic logic [32:0] model(input logic [31:0] x);
    real         r;
    logic [63:0] b;
    int          e;
    logic [22:0] keep;
    logic [28:0] rem;
    logic        inc;
    logic [31:0] res;
    if (x == 32'h0) return 33'h0;
    r    = $itor($signed(x)) / 256.0;
    b    = $realtobits(r);
    e    = int'(b[62:52]) - 1023 + 127;
    keep = b[51:29];
    rem  = b[28:0];
    inc  = (rem > 29'h1000_0000) || (rem == 29'h1000_0000 && keep[0]);
    res  = {b[63], e[7:0], keep} + {31'h0, inc};
    return {(rem != 29'h0), res};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ent_t        e;
    logic [32:0] m;
    if (!reset) begin
      q.delete();
      hold_prev    = 1'b0;
      exp_inex_cnt = 0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", {31'h0, out_valid}, 32'h1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_out: got %h with no sample pending, expected none", out_data);
        end else begin
          e = q.pop_front();
          check("out_data", out_data, e.d);
`ifdef FIX2FP_INEXACT_EN
          check("out_inexact", {31'h0, out_inexact}, {31'h0, e.inex});
          if (e.inex) exp_inex_cnt++;
`endif
          if (chk_lat) check("latency", cyc - e.acc, 32'd3);
        end
      end
      if (in_valid && in_ready) begin
        m = model(in_data);
        q.push_back('{d: m[31:0], inex: m[32], acc: cyc});
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x);
    bit a;
    a = 1'b0;
    in_valid = 1'b1;
    in_data  = x;
    for (int k = 0; k < 100 && !a; k++) begin
      @(negedge clk);
      a = in_ready;
      tick();
    end
    if (!a) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0, expected acceptance of %h", x);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() != 0 || out_valid) && k < 60) begin
      tick();
      k++;
    end
    check("drain_empty", q.size(), 32'd0);
  endtask

  logic [31:0] bp [5] = '{32'h0000_0100, 32'h0000_0280, 32'hFFFF_FE00, 32'h0123_4567, 32'h7FFF_FFFF};
  logic [31:0] rv [8] = '{32'h0100_0001, 32'h0100_0003, 32'h00FF_FFFF, 32'h7FFF_FFFF,
                          32'h0000_0001, 32'hFEFF_FFFF, 32'h0100_0005, 32'h0100_0007};

  initial begin
    int acc;
    bit a;
    logic [32:0] m;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;

    m = model(32'h0000_0100); check("pin_1p0", m[31:0], 32'h3F80_0000);
    m = model(32'hFFFF_FF00); check("pin_m1p0", m[31:0], 32'hBF80_0000);
    m = model(32'h8000_0000); check("pin_min", m[31:0], 32'hCB00_0000);
    m = model(32'h0100_0001); check("pin_tie", m[31:0], 32'h4780_0000);
    check("pin_tie_inex", {31'h0, m[32]}, 32'h1);
    m = model(32'h0100_0003); check("pin_up", m[31:0], 32'h4780_0002);
    m = model(32'h00FF_FFFF); check("pin_exact", m[31:0], 32'h477F_FFFF);
    m = model(32'h7FFF_FFFF); check("pin_carry", m[31:0], 32'h4B00_0000);
    m = model(32'h0000_0001); check("pin_lsb", m[31:0], 32'h3B80_0000);

    repeat (3) tick();
    #1 check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    tick();

    // First sample, latency and literal result
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    send(32'h0000_0100);
    @(negedge clk);
    check("t1_valid_c1", {31'h0, out_valid}, 32'h0);
    check("t1_ready_c1", {31'h0, in_ready}, 32'h1);
    tick();
    @(negedge clk);
    check("t1_valid_c2", {31'h0, out_valid}, 32'h0);
    check("t1_ready_c2", {31'h0, in_ready}, 32'h1);
    tick();
    @(negedge clk);
    check("t1_valid_c3", {31'h0, out_valid}, 32'h1);
    check("t1_data", out_data, 32'h3F80_0000);
    tick();
    drain();

    send(32'hFFFF_FF00);
    send(32'h0000_0000);
    send(32'h8000_0000);
    drain();

    for (int i = 0; i < 8; i++) send(rv[i]);
    drain();

    // Backpressure: three stages fill, then the input stalls
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    acc       = 0;
    in_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = bp[acc];
      @(negedge clk);
      a = in_ready;
      tick();
      if (a) acc++;
    end
    check("bp_accepted", acc, 32'd3);
    @(negedge clk);
    check("bp_in_ready", {31'h0, in_ready}, 32'h0);
    check("bp_out_valid", {31'h0, out_valid}, 32'h1);
    tick();
    out_ready = 1'b1;
    send(bp[3]);
    send(bp[4]);
    drain();

    // Bubble collapse
    out_ready = 1'b0;
    send(32'h0000_0180);
    tick();
    tick();
    send(32'hFFFF_FD80);
    tick();
    @(negedge clk);
    check("bub_in_ready", {31'h0, in_ready}, 32'h1);
    check("bub_out_valid", {31'h0, out_valid}, 32'h1);
    check("bub_head", out_data, 32'h3FC0_0000);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bub_out1", {31'h0, out_valid}, 32'h1);
    tick();
    @(negedge clk);
    check("bub_out2", {31'h0, out_valid}, 32'h1);
    check("bub_data2", out_data, 32'hC020_0000);
    tick();
    check("bub_empty", q.size(), 32'd0);

    // Reset with samples in flight
    send(32'h0000_0100);
    send(32'h0000_0200);
    send(32'h0000_0300);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_data", out_data, 32'h0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'h0, in_ready}, 32'h1);
    repeat (5) tick();
    chk_lat = 1'b1;
    send(32'h0000_0080);
    drain();

`ifdef FIX2FP_INEXACT_EN
    check("inexact_cnt", {16'h0, inexact_cnt}, exp_inex_cnt);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
